gen_pwm: RTL and testbench
==========================

# gen_pwm

PWM generator stage fed directly by the PWM decoder: consumes the decoded 12-bit period count (`frecuencia_out`) and high-time count (`corriente_out`) and produces the physical PWM waveform. It double-buffers both values, so decoder changes take effect only at period boundaries. When disabled, it finishes the current period before idling.

## Interface
Parameters:
- `WIDTH`, 12: width of period, duty and counter.
- `SS_STEP`, 16: duty increment per period during soft-start (used only with `GEN_PWM_SOFTSTART_EN`).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run request, level-sensitive.
- `periodo_in`  in  WIDTH  period in clk cycles (from decoder `frecuencia_out`).
- `duty_in`  in  WIDTH  high time in clk cycles (from decoder `corriente_out`).
- `pwm_out`  out  1  PWM waveform, registered.
- `fin_periodo`  out  1  high during the last cycle of each period, registered.
- `activo`  out  1  high in RUN or DRAIN.
- `cuenta`  out  WIDTH  current position in the period.

## Operation
- State machine: IDLE, RUN, DRAIN.
- Internal registers: `per_sh`, `duty_sh` (shadow), `duty_eff`.
- Reset (`rst_n`=0, any time, including mid-period): state IDLE; `cuenta`, shadows, `pwm_out`, `fin_periodo`, `activo` = 0 immediately.
- Load at IDLE exit or period boundary:
  - `per_sh` = `periodo_in`.
  - `duty_sh` = min(`duty_in`, `periodo_in`); duty ≥ period gives constant high.
  - `cuenta` = 0.
- IDLE:
  - `enable`=1 and `periodo_in`≠0 at an edge → load → RUN.
  - `periodo_in`=0 → stay IDLE.
- RUN:
  - Each edge `cuenta`+1.
  - At the edge where `cuenta` = `per_sh`-1 (boundary):
    - `enable`=1 and `periodo_in`≠0 → load, stay RUN.
    - `periodo_in`=0 → IDLE.
    - `enable`=0 → IDLE.
  - `enable`=0 at a non-boundary edge → DRAIN.
- DRAIN:
  - Counting and waveform continue unchanged.
  - `enable`=1 again → RUN, no glitch or restart.
  - Boundary → IDLE.
- `pwm_out` = 1 iff state≠IDLE and `cuenta` < `duty_eff`. In IDLE: 0.
- `fin_periodo` = 1 iff state≠IDLE and `cuenta` = `per_sh`-1.
- Inputs changing mid-period are ignored until the next boundary.
- Period 1: `cuenta` stays 0; `fin_periodo` constantly high; `pwm_out` = (`duty_sh`≥1).
- Arithmetic is unsigned. Comparisons are at WIDTH bits; soft-start sum is WIDTH+1 bits, saturating.

## Timing
- Start latency: `enable` sampled high at edge N → `activo`=1, `cuenta`=0, `pwm_out` valid in the cycle after edge N.
- Stop: `pwm_out` falls to 0 at the edge closing the last period, never mid-period.
- Outputs are registered, glitch-free, and change only on `clk` edges (except async reset).
- Duty `d`, period `p`, 0<d<p: exactly `d` high cycles followed by `p`-`d` low cycles, then repeat.

## Configuration
- `GEN_PWM_SOFTSTART_EN` defined:
  - On IDLE→RUN, `duty_eff` = min(`SS_STEP`, `duty_sh`).
  - At each boundary, `duty_eff` = min(`duty_eff`+`SS_STEP`, new `duty_sh`).
  - A drop in `duty_sh` takes effect at that boundary.
  - Ramp restarts from IDLE.
- Not defined: `duty_eff` = `duty_sh` always; `SS_STEP` unused.

## Structure
- Package `gen_pwm_pkg`:
  - state typedef: IDLE=2'b00, RUN=2'b01, DRAIN=2'b10.
  - default `WIDTH` constant.
- Optional sub-module `gen_pwm_rampa`: soft-start `duty_eff` register and saturating adder. Compiled only under `GEN_PWM_SOFTSTART_EN`.

## Test plan
- Period 3330, duty 33, enable held → `pwm_out` high 33 / low 3297 cycles; `fin_periodo` pulse every 3330 cycles; first high cycle one clock after enable edge.
- Change duty 200→1600 mid-period at period 2000 → current period keeps 200 high cycles; next period has 1600.
- Drop `enable` at `cuenta`=100 with period 500, duty 250 → DRAIN; full 250/250 period completes; IDLE at boundary; `pwm_out`=0 after.
- Duty 4000 with period 1000 → `pwm_out` constant high; `fin_periodo` every 1000.
- Period 0, or `rst_n` low at `cuenta`=37 → `pwm_out`, `activo`, `cuenta`, `fin_periodo` = 0 immediately; enable with period 0 stays IDLE.
- With `GEN_PWM_SOFTSTART_EN`, `SS_STEP`=16, period 100, duty 40 → high times 16, 32, 40, 40, …

Source files
------------

// File: rtl/gen_pwm_pkg.sv
// rtl/gen_pwm_pkg.sv - shared types and defaults for the gen_pwm PWM generator
package gen_pwm_pkg;

    localparam int GEN_PWM_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } gen_pwm_state_t;

endpackage

// File: rtl/gen_pwm_rampa.sv
// rtl/gen_pwm_rampa.sv - soft-start duty ramp (built only with GEN_PWM_SOFTSTART_EN)
`ifdef GEN_PWM_SOFTSTART_EN
import gen_pwm_pkg::*;

module gen_pwm_rampa #(
    parameter int WIDTH   = GEN_PWM_WIDTH,
    parameter int SS_STEP = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arranque_i,
    input  logic             carga_i,
    input  logic [WIDTH-1:0] duty_sh_i,
    output logic [WIDTH-1:0] duty_eff_d_o
);

    localparam logic [WIDTH:0] PASO = (WIDTH + 1)'(SS_STEP);

    logic [WIDTH-1:0] duty_eff_q, duty_eff_d;
    logic [WIDTH:0]   suma;
    logic [WIDTH-1:0] paso_sat, suma_sat, base;

    // The ramp sum saturates so a large step never wraps to a tiny duty.
    always_comb begin
        suma       = {1'b0, duty_eff_q} + PASO;
        suma_sat   = suma[WIDTH] ? '1 : suma[WIDTH-1:0];
        paso_sat   = PASO[WIDTH] ? '1 : PASO[WIDTH-1:0];
        base       = arranque_i ? paso_sat : suma_sat;
        duty_eff_d = duty_eff_q;
        if (carga_i) begin
            duty_eff_d = (base < duty_sh_i) ? base : duty_sh_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_eff_q <= '0;
        end else begin
            duty_eff_q <= duty_eff_d;
        end
    end

    assign duty_eff_d_o = duty_eff_d;

endmodule
`endif

// File: rtl/gen_pwm.sv
// rtl/gen_pwm.sv - double-buffered PWM generator with drain-on-disable; GEN_PWM_SOFTSTART_EN adds a duty ramp
import gen_pwm_pkg::*;

module gen_pwm #(
    parameter int WIDTH   = GEN_PWM_WIDTH,
    parameter int SS_STEP = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] periodo_in,
    input  logic [WIDTH-1:0] duty_in,
    output logic             pwm_out,
    output logic             fin_periodo,
    output logic             activo,
    output logic [WIDTH-1:0] cuenta
);

    localparam logic [WIDTH-1:0] UNO = WIDTH'(1);

    gen_pwm_state_t   state_q, state_d;
    logic [WIDTH-1:0] cuenta_q, cuenta_d;
    logic [WIDTH-1:0] per_sh_q, per_sh_d;
    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] duty_eff_d;
    logic [WIDTH-1:0] duty_nuevo;
    logic             pwm_q, pwm_d;
    logic             fin_q, fin_d;
    logic             pedido, frontera, carga, arranque;

    always_comb begin
        duty_nuevo = (duty_in > periodo_in) ? periodo_in : duty_in;
        pedido     = enable && (periodo_in != '0);
        frontera   = (state_q != IDLE) && (cuenta_q == per_sh_q - UNO);
        state_d    = state_q;
        cuenta_d   = cuenta_q;
        per_sh_d   = per_sh_q;
        duty_sh_d  = duty_sh_q;
        carga      = 1'b0;
        arranque   = 1'b0;
        case (state_q)
            IDLE: begin
                cuenta_d = '0;
                if (pedido) begin
                    carga    = 1'b1;
                    arranque = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN, DRAIN: begin
                // Mid-period the only decision is whether we are draining.
                if (frontera) begin
                    cuenta_d = '0;
                    if (pedido) begin
                        carga   = 1'b1;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cuenta_d = cuenta_q + UNO;
                    state_d  = enable ? RUN : DRAIN;
                end
            end
            default: begin
                state_d  = IDLE;
                cuenta_d = '0;
            end
        endcase
        if (carga) begin
            per_sh_d  = periodo_in;
            duty_sh_d = duty_nuevo;
        end
    end

`ifdef GEN_PWM_SOFTSTART_EN
    gen_pwm_rampa #(
        .WIDTH   (WIDTH),
        .SS_STEP (SS_STEP)
    ) u_rampa (
        .clk          (clk),
        .rst_n        (rst_n),
        .arranque_i   (arranque),
        .carga_i      (carga),
        .duty_sh_i    (duty_sh_d),
        .duty_eff_d_o (duty_eff_d)
    );
`else
    logic unused_rampa;
    assign unused_rampa = arranque & (SS_STEP != 0);
    assign duty_eff_d   = duty_sh_d;
`endif

    // Outputs are computed from next state so they are registered yet aligned with cuenta.
    always_comb begin
        pwm_d = (state_d != IDLE) && (cuenta_d < duty_eff_d);
        fin_d = (state_d != IDLE) && (cuenta_d == per_sh_d - UNO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cuenta_q  <= '0;
            per_sh_q  <= '0;
            duty_sh_q <= '0;
            pwm_q     <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cuenta_q  <= cuenta_d;
            per_sh_q  <= per_sh_d;
            duty_sh_q <= duty_sh_d;
            pwm_q     <= pwm_d;
            fin_q     <= fin_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign fin_periodo = fin_q;
    assign activo      = (state_q != IDLE);
    assign cuenta      = cuenta_q;

endmodule

// File: tb/tb_gen_pwm.sv
// tb/tb_gen_pwm.sv - self-checking bench for gen_pwm against a period-level model
module tb_gen_pwm;

    localparam int W  = 12;
    localparam int SS = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b0;
    logic [W-1:0] periodo_in = '0;
    logic [W-1:0] duty_in = '0;
    logic         pwm_out, fin_periodo, activo;
    logic [W-1:0] cuenta;

    int checks = 0;
    int errors = 0;
    int nprint = 0;

    always #5 clk = ~clk;

    gen_pwm #(.WIDTH(W), .SS_STEP(SS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .periodo_in  (periodo_in),
        .duty_in     (duty_in),
        .pwm_out     (pwm_out),
        .fin_periodo (fin_periodo),
        .activo      (activo),
        .cuenta      (cuenta)
    );

    // Model: "on" or not, position inside the period, and the latched period/duty.
    int m_on, m_pos, m_per, m_duty, m_eff;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic m_load(input bit first);
        m_per  = int'(periodo_in);
        m_duty = imin(int'(duty_in), int'(periodo_in));
        m_pos  = 0;
`ifdef GEN_PWM_SOFTSTART_EN
        m_eff  = first ? imin(SS, m_duty) : imin(imin(m_eff + SS, 4095), m_duty);
`else
        m_eff  = first ? m_duty : m_duty;
`endif
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on = 0; m_pos = 0; m_per = 0; m_duty = 0; m_eff = 0;
        end else if (m_on == 0) begin
            if (enable && periodo_in != 0) begin
                m_on = 1;
                m_load(1'b1);
            end
        end else if (m_pos == m_per - 1) begin
            if (enable && periodo_in != 0) m_load(1'b0);
            else begin
                m_on = 0; m_pos = 0;
            end
        end else begin
            m_pos = m_pos + 1;
        end
    end

    always @(negedge clk) begin
        automatic bit e_pwm = (m_on != 0) && (m_pos < m_eff);
        automatic bit e_fin = (m_on != 0) && (m_pos == m_per - 1);
        automatic bit e_act = (m_on != 0);
        checks++;
        if (pwm_out !== e_pwm || fin_periodo !== e_fin || activo !== e_act || int'(cuenta) != m_pos || $isunknown(cuenta)) begin
            errors++;
            if (nprint < 10)
                $display("FAIL model_cycle t=%0t: pwm %b/%b fin %b/%b activo %b/%b cuenta %0d/%0d (got/required)",
                         $time, pwm_out, e_pwm, fin_periodo, e_fin, activo, e_act, cuenta, m_pos);
            nprint++;
        end
    end

    // Per-period high-time and length log built from the DUT outputs.
    int hi_q[$], len_q[$];
    int hi_c = 0, len_c = 0;
    always @(negedge clk) begin
        if (activo) begin
            len_c++;
            hi_c += int'(pwm_out);
            if (fin_periodo) begin
                hi_q.push_back(hi_c);
                len_q.push_back(len_c);
                hi_c = 0; len_c = 0;
            end
        end else begin
            hi_c = 0; len_c = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int lim);
        checks++;
        errors++;
        $display("FAIL %s: event not seen within %0d cycles, required it", name, lim);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_cuenta(input int v, input int lim);
        for (int n = 0; n < lim; n++) begin
            tick(1);
            if (int'(cuenta) == v) return;
        end
        timeout("wait_cuenta", lim);
    endtask

    task automatic wait_periods(input int k, input int lim);
        for (int n = 0; n < lim; n++) begin
            if (len_q.size() >= k) return;
            tick(1);
        end
        timeout("wait_periods", lim);
    endtask

    task automatic wait_idle(input int lim);
        for (int n = 0; n < lim; n++) begin
            if (!activo) return;
            tick(1);
        end
        timeout("wait_idle", lim);
    endtask

    task automatic chk_period(input string name, input int idx, input int hi, input int len);
        chk({name, "_high"}, (idx < hi_q.size()) ? hi_q[idx] : -1, hi);
        chk({name, "_len"}, (idx < len_q.size()) ? len_q[idx] : -1, len);
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst_n  = 1'b0;
        tick(2);
        rst_n  = 1'b1;
        hi_q.delete();
        len_q.delete();
    endtask

    task automatic start(input int per, input int duty);
        periodo_in = W'(per);
        duty_in    = W'(duty);
        enable     = 1'b1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_activo", int'(activo), 0);
        chk("reset_cuenta", int'(cuenta), 0);
        chk("reset_fin", int'(fin_periodo), 0);
        tick(1);
        rst_n = 1'b1;

        // Period 3330, duty 33; first high cycle right after the enable edge.
        start(3330, 33);
        @(posedge clk); #1;
        chk("start_cuenta", int'(cuenta), 0);
        chk("start_pwm", int'(pwm_out), 1);
        chk("start_activo", int'(activo), 1);
        #1;
        wait_periods(2, 7000);
        chk_period("p3330_0", 0, 33, 3330);
        chk_period("p3330_1", 1, 33, 3330);
        wait_cuenta(37, 100);
        rst_n = 1'b0;
        #1;
        chk("midreset_pwm", int'(pwm_out), 0);
        chk("midreset_activo", int'(activo), 0);
        chk("midreset_cuenta", int'(cuenta), 0);
        chk("midreset_fin", int'(fin_periodo), 0);
        #1;
        do_reset();

        // Duty change mid-period is deferred to the next period.
        start(2000, 200);
        wait_cuenta(500, 600);
        duty_in = W'(1600);
        wait_periods(2, 4500);
        chk_period("dchg_0", 0, 200, 2000);
        chk_period("dchg_1", 1, 1600, 2000);
        do_reset();

        // Disable at cuenta 100 drains the full period, then idles.
        start(500, 250);
        wait_cuenta(100, 200);
        enable = 1'b0;
        tick(1);
        chk("drain_activo", int'(activo), 1);
        wait_idle(600);
        chk("drain_periods", len_q.size(), 1);
        chk_period("drain", 0, 250, 500);
        tick(3);
        chk("drain_after_pwm", int'(pwm_out), 0);
        chk("drain_after_activo", int'(activo), 0);
        do_reset();

        // Re-enable during drain: waveform continues without restart.
        start(50, 20);
        wait_cuenta(10, 60);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        wait_periods(2, 200);
        chk_period("reen_0", 0, 20, 50);
        chk_period("reen_1", 1, 20, 50);
        do_reset();

        // Duty above period gives constant high.
        start(1000, 4000);
        wait_periods(2, 2200);
        chk_period("sat_0", 0, 1000, 1000);
        chk_period("sat_1", 1, 1000, 1000);
        do_reset();

        // Period zero never leaves idle.
        start(0, 5);
        tick(5);
        chk("p0_activo", int'(activo), 0);
        chk("p0_pwm", int'(pwm_out), 0);
        chk("p0_cuenta", int'(cuenta), 0);
        do_reset();

        // Period one: fin constantly high, pwm follows duty>=1.
        start(1, 1);
        tick(3);
        chk("p1_fin", int'(fin_periodo), 1);
        chk("p1_pwm", int'(pwm_out), 1);
        chk("p1_cuenta", int'(cuenta), 0);
        duty_in = '0;
        tick(2);
        chk("p1_d0_pwm", int'(pwm_out), 0);
        chk("p1_d0_fin", int'(fin_periodo), 1);
        do_reset();

        // Period 7 duty 3 followed by a period change applied at the boundary.
        start(7, 3);
        tick(3);
        periodo_in = W'(4);
        duty_in    = W'(1);
        wait_periods(3, 40);
        chk_period("p7", 0, 3, 7);
        chk_period("p4", 1, 1, 4);
        do_reset();

`ifdef GEN_PWM_SOFTSTART_EN
        start(100, 40);
        wait_periods(4, 500);
        chk_period("ss_0", 0, 16, 100);
        chk_period("ss_1", 1, 32, 100);
        chk_period("ss_2", 2, 40, 100);
        chk_period("ss_3", 3, 40, 100);
        do_reset();
`endif

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
